// File: rtl/sonar_scheduler.sv
// rtl/sonar_scheduler.sv - round-robin ultrasonic sensor scheduler with echo timing and result registers
module sonar_scheduler #(
    parameter int N_SENS   = 4,
    parameter int TRIG_CYC = 600,
    parameter int RISE_MAX = 50000,
    parameter int ECHO_MAX = 1600000,
    parameter int GAP_CYC  = 3000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] echo,
    output logic [3:0] trig,
    input  logic [1:0] rd_sel,
    output logic [8:0] rd_dist,
    output logic       rd_err,
    output logic       upd,
    output logic [1:0] upd_id,
    output logic       busy
);
    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_GAP} state_t;

    localparam logic [21:0] LP_TRIG_LAST = 22'(TRIG_CYC - 1);
    localparam logic [21:0] LP_RISE_LAST = 22'(RISE_MAX - 1);
    localparam logic [21:0] LP_GAP_LAST  = 22'(GAP_CYC - 1);
    localparam logic [20:0] LP_ECHO_MAX  = 21'(ECHO_MAX);
    localparam logic [1:0]  LP_LAST_SENS = 2'(N_SENS - 1);

    state_t          r_state, w_next;
    logic [21:0]     r_cnt;
    logic [20:0]     r_ecnt, w_ecnt_next;
    logic [1:0]      r_cur;
    logic [3:0]      r_sync1, r_sync2;
    logic [3:0][8:0] r_dist;
    logic [3:0]      r_err;
    logic            r_upd;
    logic [1:0]      r_upd_id;
    logic            w_echo, w_store, w_tmo, w_adv;
    logic [24:0]     w_prod;
    logic [8:0]      w_dist;

    assign w_echo = r_sync2[r_cur];
    assign w_prod = 25'(r_ecnt) * 25'd11;
    assign w_dist = (w_prod[24:15] > 10'd511) ? 9'd511 : w_prod[23:15];

    always_comb begin
        w_next      = r_state;
        w_ecnt_next = r_ecnt;
        w_store     = 1'b0;
        w_tmo       = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: if (en) w_next = S_TRIG;
            S_TRIG: if (r_cnt == LP_TRIG_LAST) w_next = S_WAIT_RISE;
            S_WAIT_RISE: begin
                if (w_echo) begin
                    w_next      = S_MEASURE;
                    w_ecnt_next = 21'd1;
                end else if (r_cnt == LP_RISE_LAST) begin
                    w_store = 1'b1;
                    w_tmo   = 1'b1;
                    w_next  = S_GAP;
                end
            end
            S_MEASURE: begin
                if (!w_echo) begin
                    w_store = 1'b1;
                    w_next  = S_GAP;
                end else if ((r_ecnt + 21'd1) >= LP_ECHO_MAX) begin
                    // this high cycle brings the count to ECHO_MAX: overrange
                    w_store = 1'b1;
                    w_tmo   = 1'b1;
                    w_next  = S_GAP;
                end else begin
                    w_ecnt_next = r_ecnt + 21'd1;
                end
            end
            S_GAP: begin
                if (r_cnt == LP_GAP_LAST) begin
                    w_adv  = 1'b1;
                    w_next = en ? S_TRIG : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ecnt   <= '0;
            r_cur    <= '0;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_dist   <= '0;
            r_err    <= '0;
            r_upd    <= 1'b0;
            r_upd_id <= '0;
        end else begin
            r_sync1 <= echo;
            r_sync2 <= r_sync1;
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || w_next == S_IDLE) ? 22'd0 : r_cnt + 22'd1;
            r_ecnt  <= w_ecnt_next;
            r_upd   <= w_store;
            if (w_store) begin
                r_upd_id       <= r_cur;
                r_dist[r_cur]  <= w_tmo ? 9'd511 : w_dist;
                r_err[r_cur]   <= w_tmo;
            end
            if (w_adv) r_cur <= (r_cur == LP_LAST_SENS) ? 2'd0 : r_cur + 2'd1;
        end
    end

    // trig decodes registered state so a reset edge drops it immediately
    assign trig    = (r_state == S_TRIG) ? (4'b0001 << r_cur) : 4'b0000;
    assign rd_dist = r_dist[rd_sel];
    assign rd_err  = r_err[rd_sel];
    assign upd     = r_upd;
    assign upd_id  = r_upd_id;
    assign busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_sonar_scheduler.sv
// tb/tb_sonar_scheduler.sv - randomized self-checking bench for sonar_scheduler
module tb_sonar_scheduler;
    localparam int TC = 20;
    localparam int RM = 300;
    localparam int EM = 8000;
    localparam int GC = 60;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] echo;
    logic [1:0] rd_sel;
    logic [3:0] trig;
    logic [8:0] rd_dist;
    logic       rd_err, upd, busy;
    logic [1:0] upd_id;

    sonar_scheduler #(.N_SENS(4), .TRIG_CYC(TC), .RISE_MAX(RM), .ECHO_MAX(EM), .GAP_CYC(GC)) dut (
        .clk(clk), .rst(rst), .en(en), .echo(echo), .trig(trig), .rd_sel(rd_sel),
        .rd_dist(rd_dist), .rd_err(rd_err), .upd(upd), .upd_id(upd_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int cyc = 0, n_upd = 0, upd_cyc = 0, dbl_upd = 0, multi_trig = 0;
    bit prev_upd = 0;
    int upd_q[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (upd === 1'b1) begin
            n_upd++;
            upd_cyc = cyc;
            upd_q.push_back(int'(upd_id));
            if (prev_upd) dbl_upd++;
        end
        prev_upd = (upd === 1'b1);
        if ($countones(trig) > 1) multi_trig++;
    end

    int m_dist[4];
    bit m_err[4];
    int m_cur = 0;
    int chain_cyc = 0;
    bit chain_ok = 0;

    task automatic check_all_reads(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            chk({tag, "_dist"}, rd_dist, m_dist[i]);
            chk({tag, "_err"}, rd_err, m_err[i]);
        end
    endtask

    task automatic shot(input bit has_echo, input int d, input int w, input bit noise, input bit drop_en);
        int s, f, n0, c, hi, start, exp_upd, twidth, badtrig, base_upd, exp_dist, guard, got_id;
        bit exp_tmo, done;
        guard = 0;
        while (trig === 4'b0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (trig === 4'b0) begin
            chk("trig_wait_timeout", 0, 1);
            return;
        end
        s = cyc;
        chk("trig_sel", trig, 4'b1 << m_cur);
        if (chain_ok) chk("gap_len", s - chain_cyc, GC);
        f = s + TC;
        n0 = f + d;
        base_upd = n_upd;
        twidth = 0;
        badtrig = 0;
        done = 0;
        while (!done) begin
            c = cyc;
            if (trig !== 4'b0) begin
                twidth++;
                if (trig !== (4'b1 << m_cur)) badtrig++;
            end
            if (has_echo && c == n0) echo[m_cur] = 1'b1;
            if (has_echo && c == n0 + w) echo[m_cur] = 1'b0;
            if (noise)
                for (int j = 0; j < 4; j++)
                    if (j != m_cur) echo[j] = (n_upd == base_upd) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (drop_en && has_echo && c == n0 + 5) en = 1'b0;
            if (n_upd != base_upd && (!has_echo || c >= n0 + w)) done = 1;
            else if (c - s > TC + RM + w + EM + 200) begin
                chk("upd_wait_timeout", 0, 1);
                done = 1;
            end
            if (!done) @(negedge clk);
        end
        echo = 4'b0;
        // expected outcome from the echo pulse as seen through the 2-cycle synchronizer
        exp_dist = 511;
        exp_tmo = 1;
        if (!has_echo) begin
            exp_upd = f + RM;
        end else begin
            start = (n0 + 2 > f) ? n0 + 2 : f;
            hi = n0 + w + 1 - start + 1;
            if (hi >= EM) begin
                exp_upd = start + EM;
            end else begin
                exp_tmo = 0;
                exp_dist = (hi * 11) >>> 15;
                if (exp_dist > 511) exp_dist = 511;
                exp_upd = n0 + w + 3;
            end
        end
        chk("trig_width", twidth, TC);
        chk("trig_onehot", badtrig, 0);
        chk("upd_count", n_upd - base_upd, 1);
        got_id = (upd_q.size() > 0) ? upd_q.pop_front() : -1;
        chk("upd_id", got_id, m_cur);
        chk("upd_time", upd_cyc, exp_upd);
        m_dist[m_cur] = exp_dist;
        m_err[m_cur] = exp_tmo;
        check_all_reads("result");
        chain_cyc = upd_cyc;
        chain_ok = 1;
        m_cur = (m_cur + 1) % 4;
    endtask

    task automatic reset_mid_trig();
        int guard, base;
        guard = 0;
        while (trig === 4'b0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_trig_seen", (trig !== 4'b0), 1);
        repeat (5) @(negedge clk);
        base = n_upd;
        rst = 1'b1;
        en = 1'b0;
        @(negedge clk);
        chk("rst_trig_drop", trig, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_no_upd", n_upd - base, 0);
        for (int i = 0; i < 4; i++) begin
            m_dist[i] = 0;
            m_err[i] = 0;
        end
        m_cur = 0;
        chain_ok = 0;
        upd_q.delete();
        check_all_reads("rst_read");
        repeat (RM + 20) @(negedge clk);
        chk("rst_no_late_upd", n_upd - base, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        rst = 1'b1;
        en = 1'b0;
        echo = 4'b0;
        rd_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            m_dist[i] = 0;
            m_err[i] = 0;
        end
        repeat (5) @(negedge clk);
        chk("reset_trig", trig, 0);
        chk("reset_busy", busy, 0);
        chk("reset_upd", upd, 0);
        chk("reset_upd_id", upd_id, 0);
        rst = 1'b0;
        @(negedge clk);
        check_all_reads("reset_read");
        chk("idle_stays", busy, 0);

        en = 1'b1;
        shot(1, 5, 3000, 0, 0);
        shot(0, 0, 0, 1, 0);
        shot(1, 10, EM + 20, 0, 0);
        shot(1, 3, EM - 1, 1, 0);
        shot(1, -4, 200, 0, 0);
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 4) == 0) shot(0, 0, 0, 1, 0);
            else shot(1, $urandom_range(2, RM - 10), $urandom_range(1, 6000), 1, 0);
        end
        while (m_cur != 3) shot(1, $urandom_range(2, RM - 10), $urandom_range(1, 400), 1, 0);
        shot(1, 20, 1500, 1, 1);

        repeat (GC + 10) @(negedge clk);
        chk("drop_busy", busy, 0);
        nz = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (trig !== 4'b0) nz++;
        end
        chk("drop_no_trig", nz, 0);
        chain_ok = 0;

        en = 1'b1;
        shot(1, 7, 2500, 0, 0);
        reset_mid_trig();
        en = 1'b1;
        shot(1, 9, 1000, 1, 0);

        chk("multi_trig", multi_trig, 0);
        chk("double_upd", dbl_upd, 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
